// File: rtl/f8_mem_iface_if.sv
// Bundle of the CPU-side strobes and data bus plus the memory request port
// of the F8 memory responder. The slave side is the responder itself, and
// the master side is whatever stands in for the CPU and the memory fabric.
interface f8_mem_iface_if #(
  parameter int ADDR_W = 16
);
  logic [4:0]        romc;
  logic              cyc_stb;
  logic              db_stb;
  logic [7:0]        db_in;
  logic [7:0]        db_out;
  logic              db_oe;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              proto_err;

  modport master (
    output romc, cyc_stb, db_stb, db_in, mem_ack, mem_rdata,
    input  db_out, db_oe, mem_req, mem_we, mem_addr, mem_wdata, proto_err
  );

  modport slave (
    input  romc, cyc_stb, db_stb, db_in, mem_ack, mem_rdata,
    output db_out, db_oe, mem_req, mem_we, mem_addr, mem_wdata, proto_err
  );
endinterface

// File: rtl/f8_mem_iface.sv
// F8 memory responder: decodes ROMC once per machine cycle, keeps the
// PC0/PC1/DC0/DC1 address registers, and serves fetch/readback bytes from
// ROM/RAM windows through a req/ack memory port guarded by a timeout.
// The byte-lane ROMC operations address bits [15:8], so ADDR_W must be >= 16.
module f8_mem_iface #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] ROM_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] ROM_LAST = 16'h2fff,
  parameter logic [ADDR_W-1:0] RAM_BASE = 16'h8000,
  parameter logic [ADDR_W-1:0] RAM_LAST = 16'h81ff,
  parameter int                TIMEOUT  = 8
) (
  input logic           clk,
  input logic           rst,
  f8_mem_iface_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_DRIVE,
    S_WR_WAIT
  } state_t;

  // Window spans let the range test be one modular subtract-and-compare,
  // which stays correct when a window starts at address zero.
  localparam logic [ADDR_W-1:0] ROM_SPAN   = ROM_LAST - ROM_BASE;
  localparam logic [ADDR_W-1:0] RAM_SPAN   = RAM_LAST - RAM_BASE;
  localparam logic [7:0]        TIMER_LAST = 8'(TIMEOUT - 1);

  function automatic logic in_rom(input logic [ADDR_W-1:0] a);
    return (a - ROM_BASE) <= ROM_SPAN;
  endfunction

  function automatic logic in_ram(input logic [ADDR_W-1:0] a);
    return (a - RAM_BASE) <= RAM_SPAN;
  endfunction

  function automatic logic is_fetch(input logic [4:0] c);
    return c inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h0C, 5'h0E, 5'h11};
  endfunction

  function automatic logic is_readback(input logic [4:0] c);
    return c inside {5'h06, 5'h07, 5'h09, 5'h0B, 5'h1E, 5'h1F};
  endfunction

  state_t            state_q, state_d;
  logic [4:0]        romc_q, romc_d;
  logic              open_q, open_d;
  logic [ADDR_W-1:0] pc0_q, pc0_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic [ADDR_W-1:0] dc0_q, dc0_d;
  logic [ADDR_W-1:0] dc1_q, dc1_d;
  logic [7:0]        db_out_q, db_out_d;
  logic              db_oe_q, db_oe_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              proto_err_q, proto_err_d;
  logic [7:0]        timer_q, timer_d;

  logic              db_end;
  logic [ADDR_W-1:0] sdb;
  logic [ADDR_W-1:0] fetch_addr;

  // A db_stb only counts when a machine cycle is open.
  assign db_end = bus.db_stb && open_q;
  assign sdb    = {{(ADDR_W-8){bus.db_in[7]}}, bus.db_in};

  // Next-state: close the old cycle (register updates, write issue), advance
  // the memory handshake, then open the new cycle from the updated registers.
  always_comb begin
    state_d     = state_q;
    romc_d      = romc_q;
    open_d      = open_q;
    pc0_d       = pc0_q;
    pc1_d       = pc1_q;
    dc0_d       = dc0_q;
    dc1_d       = dc1_q;
    db_out_d    = db_out_q;
    db_oe_d     = db_oe_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    proto_err_d = 1'b0;
    timer_d     = timer_q;
    fetch_addr  = '0;

    if (db_end) begin
      case (romc_q)
        5'h00, 5'h03: pc0_d = pc0_q + 1'b1;
        5'h01:        pc0_d = pc0_q + sdb + 1'b1;
        5'h02, 5'h05: dc0_d = dc0_q + 1'b1;
        5'h04:        pc1_d = pc0_q;
        5'h0D:        pc1_d = pc0_q + 1'b1;
        5'h08: begin
          pc1_d = pc0_q;
          pc0_d = ADDR_W'({bus.db_in, bus.db_in});
        end
        5'h12: begin
          pc1_d       = pc0_q;
          pc0_d[7:0]  = bus.db_in;
        end
        5'h0A:        dc0_d = dc0_q + sdb;
        5'h0C, 5'h17: pc0_d[7:0]  = bus.db_in;
        5'h0F, 5'h14: pc0_d[15:8] = bus.db_in;
        5'h15:        pc1_d[15:8] = bus.db_in;
        5'h18:        pc1_d[7:0]  = bus.db_in;
        5'h0E, 5'h19: dc0_d[7:0]  = bus.db_in;
        5'h11, 5'h16: dc0_d[15:8] = bus.db_in;
        5'h1D: begin
          dc0_d = dc1_q;
          dc1_d = dc0_q;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_RD_WAIT: begin
        if (bus.cyc_stb || db_end) begin
          // Cycle ended or restarted before data arrived: abandon the read.
          mem_req_d   = 1'b0;
          proto_err_d = 1'b1;
          state_d     = S_IDLE;
        end else if (bus.mem_ack) begin
          db_out_d  = bus.mem_rdata;
          db_oe_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_DRIVE;
        end else if (timer_q == TIMER_LAST) begin
          mem_req_d   = 1'b0;
          proto_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_WR_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_IDLE;
        end else if (bus.cyc_stb || timer_q == TIMER_LAST) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          proto_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DRIVE: begin
        if (db_end || bus.cyc_stb) begin
          db_oe_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    if (db_end) begin
      open_d  = 1'b0;
      db_oe_d = 1'b0;
      if (romc_q == 5'h05 && in_ram(dc0_q)) begin
        if (bus.cyc_stb) begin
          // A new cycle starting on the same clock pre-empts the write.
          proto_err_d = 1'b1;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = dc0_q;
          mem_wdata_d = bus.db_in;
          timer_d     = 8'd0;
          state_d     = S_WR_WAIT;
        end
      end
    end

    if (bus.cyc_stb) begin
      open_d     = 1'b1;
      romc_d     = bus.romc;
      db_oe_d    = 1'b0;
      fetch_addr = (bus.romc == 5'h02) ? dc0_d : pc0_d;
      if (is_readback(bus.romc)) begin
        db_oe_d = 1'b1;
        case (bus.romc)
          5'h06:   db_out_d = dc0_d[15:8];
          5'h07:   db_out_d = pc1_d[15:8];
          5'h09:   db_out_d = dc0_d[7:0];
          5'h0B:   db_out_d = pc1_d[7:0];
          5'h1E:   db_out_d = pc0_d[7:0];
          default: db_out_d = pc0_d[15:8];
        endcase
      end
      if (is_fetch(bus.romc) && (in_rom(fetch_addr) || in_ram(fetch_addr))) begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = fetch_addr;
        timer_d    = 8'd0;
        state_d    = S_RD_WAIT;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      romc_q      <= '0;
      open_q      <= 1'b0;
      pc0_q       <= '0;
      pc1_q       <= '0;
      dc0_q       <= '0;
      dc1_q       <= '0;
      db_out_q    <= 8'h00;
      db_oe_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      proto_err_q <= 1'b0;
      timer_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      romc_q      <= romc_d;
      open_q      <= open_d;
      pc0_q       <= pc0_d;
      pc1_q       <= pc1_d;
      dc0_q       <= dc0_d;
      dc1_q       <= dc1_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      proto_err_q <= proto_err_d;
      timer_q     <= timer_d;
    end
  end

  assign bus.db_out    = db_out_q;
  assign bus.db_oe     = db_oe_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_f8_mem_iface.sv
// Bench for f8_mem_iface: directed scenarios plus randomized ROMC cycles,
// checked against a plain-arithmetic model of the F8 address registers and
// a byte-array memory that also serves the DUT's memory port.
module tb_f8_mem_iface;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  f8_mem_iface_if #(.ADDR_W(16)) bus ();

  f8_mem_iface #(
    .ADDR_W(16), .ROM_BASE(16'h0000), .ROM_LAST(16'h2fff),
    .RAM_BASE(16'h8000), .RAM_LAST(16'h81ff), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int perr_seen = 0;

  // Reference model state.
  int pc0, pc1, dc0, dc1;
  logic [7:0] ram_m [0:511];

  always @(negedge clk) if (bus.proto_err) perr_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_rom(input int a);
    return a >= 0 && a <= 'h2fff;
  endfunction

  function automatic bit in_ram(input int a);
    return a >= 'h8000 && a <= 'h81ff;
  endfunction

  function automatic logic [7:0] rom_byte(input int a);
    int v;
    v = (a & 'hFF) + 'h2A + ((a >> 8) & 'hFF) * 3;
    return v[7:0];
  endfunction

  function automatic logic [7:0] mem_rd(input int a);
    if (in_ram(a)) return ram_m[a - 'h8000];
    return rom_byte(a);
  endfunction

  // Register effects of a completed cycle, straight from the ROMC table.
  task automatic model_update(input logic [4:0] code, input logic [7:0] db);
    int d, sd, t;
    d  = int'(db);
    sd = (d >= 128) ? d - 256 : d;
    case (code)
      5'h00, 5'h03: pc0 = pc0 + 1;
      5'h01:        pc0 = pc0 + sd + 1;
      5'h02, 5'h05: dc0 = dc0 + 1;
      5'h04:        pc1 = pc0;
      5'h0D:        pc1 = pc0 + 1;
      5'h08: begin pc1 = pc0; pc0 = d * 257; end
      5'h12: begin pc1 = pc0; pc0 = (pc0 & 'hFF00) | d; end
      5'h0A:        dc0 = dc0 + sd;
      5'h0C, 5'h17: pc0 = (pc0 & 'hFF00) | d;
      5'h0F, 5'h14: pc0 = (pc0 & 'h00FF) | (d << 8);
      5'h15:        pc1 = (pc1 & 'h00FF) | (d << 8);
      5'h18:        pc1 = (pc1 & 'hFF00) | d;
      5'h0E, 5'h19: dc0 = (dc0 & 'hFF00) | d;
      5'h11, 5'h16: dc0 = (dc0 & 'h00FF) | (d << 8);
      5'h1D: begin t = dc0; dc0 = dc1; dc1 = t; end
      default: ;
    endcase
    pc0 &= 'hFFFF; pc1 &= 'hFFFF; dc0 &= 'hFFFF; dc1 &= 'hFFFF;
  endtask

  // One machine cycle: cyc_stb, memory/readback phase, db_stb, write phase.
  // ack_dly < 0 withholds mem_ack to provoke the timeout.
  task automatic do_cycle(input logic [4:0] code, input logic [7:0] db, input int ack_dly);
    int addr, perr0, req_cnt, exp_perr;
    bit fetch, rb, hit, whit;
    logic [7:0] rbv, rd;
    perr0    = perr_seen;
    exp_perr = 0;
    fetch = code inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h0C, 5'h0E, 5'h11};
    rb    = code inside {5'h06, 5'h07, 5'h09, 5'h0B, 5'h1E, 5'h1F};
    addr  = (code == 5'h02) ? dc0 : pc0;
    hit   = fetch && (in_rom(addr) || in_ram(addr));
    case (code)
      5'h06:   rbv = 8'(dc0 >> 8);
      5'h07:   rbv = 8'(pc1 >> 8);
      5'h09:   rbv = 8'(dc0);
      5'h0B:   rbv = 8'(pc1);
      5'h1E:   rbv = 8'(pc0);
      default: rbv = 8'(pc0 >> 8);
    endcase

    @(negedge clk);
    bus.romc    = code;
    bus.cyc_stb = 1'b1;
    @(negedge clk);
    bus.cyc_stb = 1'b0;

    if (hit) begin
      check("rd_req", bus.mem_req, 1);
      check("rd_addr", bus.mem_addr, addr);
      check("rd_we", bus.mem_we, 0);
      if (ack_dly < 0) begin
        req_cnt = 0;
        for (int i = 0; i < 30; i++) begin
          req_cnt += int'(bus.mem_req);
          @(negedge clk);
        end
        check("to_req_cycles", req_cnt, TIMEOUT);
        check("to_oe", bus.db_oe, 0);
        exp_perr = 1;
      end else begin
        for (int i = 0; i < ack_dly; i++) @(negedge clk);
        check("rd_req_hold", bus.mem_req, 1);
        rd = mem_rd(addr);
        bus.mem_rdata = rd;
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'($urandom);
        check("rd_oe", bus.db_oe, 1);
        check("rd_data", bus.db_out, rd);
        check("rd_req_drop", bus.mem_req, 0);
      end
    end else if (rb) begin
      check("rb_oe", bus.db_oe, 1);
      check("rb_data", bus.db_out, rbv);
    end else begin
      check("no_req", bus.mem_req, 0);
      check("no_oe", bus.db_oe, 0);
    end

    bus.db_in  = db;
    bus.db_stb = 1'b1;
    @(negedge clk);
    bus.db_stb = 1'b0;
    bus.db_in  = 8'($urandom);
    check("end_oe", bus.db_oe, 0);

    if (code == 5'h05) begin
      whit = in_ram(dc0);
      check("wr_req", bus.mem_req, whit);
      if (whit) begin
        check("wr_we", bus.mem_we, 1);
        check("wr_addr", bus.mem_addr, dc0);
        check("wr_data", bus.mem_wdata, db);
        ram_m[dc0 - 'h8000] = db;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("wr_req_drop", bus.mem_req, 0);
      end
    end

    model_update(code, db);
    check("perr", perr_seen - perr0, exp_perr);
    $display("romc %02h db %02h ack %0d -> pc0 %04h pc1 %04h dc0 %04h dc1 %04h",
             code, db, ack_dly, pc0, pc1, dc0, dc1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] code;
    logic [7:0] db;
    int dly, sel;

    for (int i = 0; i < 512; i++) ram_m[i] = 8'($urandom);
    pc0 = 0; pc1 = 0; dc0 = 0; dc1 = 0;
    bus.romc = '0; bus.cyc_stb = 1'b0; bus.db_stb = 1'b0; bus.db_in = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_db_out", bus.db_out, 8'h00);
    check("rst_db_oe", bus.db_oe, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_proto_err", bus.proto_err, 0);

    // Reset in the middle of a read; the late ack must be ignored.
    bus.romc = 5'h00; bus.cyc_stb = 1'b1;
    @(negedge clk);
    bus.cyc_stb = 1'b0;
    check("mid_rst_req", bus.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_drop", bus.mem_req, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hC3;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("late_ack_oe", bus.db_oe, 0);
    check("late_ack_perr", bus.proto_err, 0);

    // Directed scenarios.
    do_cycle(5'h00, 8'h00, 3);
    do_cycle(5'h1E, 8'h00, 0);
    do_cycle(5'h0F, 8'h00, 0); do_cycle(5'h17, 8'h10, 0);
    do_cycle(5'h01, 8'hFE, 1);
    do_cycle(5'h1E, 8'h00, 0); do_cycle(5'h1F, 8'h00, 0);
    do_cycle(5'h16, 8'h80, 0); do_cycle(5'h19, 8'h00, 0);
    do_cycle(5'h0A, 8'h80, 0);
    do_cycle(5'h06, 8'h00, 0); do_cycle(5'h09, 8'h00, 0);
    do_cycle(5'h16, 8'h81, 0); do_cycle(5'h19, 8'hFF, 0);
    do_cycle(5'h05, 8'h55, 0);
    do_cycle(5'h05, 8'hAA, 0);
    do_cycle(5'h06, 8'h00, 0); do_cycle(5'h09, 8'h00, 0);
    do_cycle(5'h16, 8'h81, 0); do_cycle(5'h19, 8'hFF, 0);
    do_cycle(5'h02, 8'h00, 0);
    do_cycle(5'h14, 8'h40, 0); do_cycle(5'h17, 8'h00, 0);
    do_cycle(5'h00, 8'h00, 2);
    do_cycle(5'h1E, 8'h00, 0);
    do_cycle(5'h16, 8'h01, 0); do_cycle(5'h19, 8'h00, 0);
    do_cycle(5'h02, 8'h00, -1);
    do_cycle(5'h09, 8'h00, 0);
    do_cycle(5'h16, 8'hAB, 0); do_cycle(5'h19, 8'hCD, 0);
    do_cycle(5'h1D, 8'h00, 0);
    do_cycle(5'h16, 8'h12, 0); do_cycle(5'h19, 8'h34, 0);
    do_cycle(5'h1D, 8'h00, 0);
    do_cycle(5'h06, 8'h00, 0); do_cycle(5'h09, 8'h00, 0);
    do_cycle(5'h1D, 8'h00, 0);
    do_cycle(5'h06, 8'h00, 0); do_cycle(5'h09, 8'h00, 0);
    do_cycle(5'h14, 8'hFF, 0); do_cycle(5'h17, 8'hFF, 0);
    do_cycle(5'h00, 8'h00, 0);
    do_cycle(5'h1F, 8'h00, 0); do_cycle(5'h1E, 8'h00, 0);

    // Randomized cycles; data bytes are biased toward window high bytes.
    for (int n = 0; n < 250; n++) begin
      code = 5'($urandom_range(0, 31));
      sel  = $urandom_range(0, 7);
      case (sel)
        0:       db = 8'h00;
        1:       db = 8'h80;
        2:       db = 8'h81;
        3:       db = 8'($urandom_range(0, 'h2f));
        default: db = 8'($urandom);
      endcase
      dly = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
      do_cycle(code, db, dly);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/f8_mem_iface.md
# f8_mem_iface

Synthesisable, cycle-accurate replacement for the behavioural F8 memory responder. It decodes the CPU's 5-bit ROMC code once per machine cycle and maintains the PC0/PC1/DC0/DC1 address registers. It serves instruction, data and register-readback bytes onto the data bus from parametrised ROM and RAM windows through a req/ack memory port with a timeout. It sits between `f8_3850` and the system memory fabric, taking the role of the 3851/3853 address logic.

## Interface
- `ADDR_W`, default 16: address register and memory address width.
- `ROM_BASE` / `ROM_LAST`, default 16'h0000 / 16'h2fff: inclusive ROM window, read-only.
- `RAM_BASE` / `RAM_LAST`, default 16'h8000 / 16'h81ff: inclusive RAM window, read/write.
- `TIMEOUT`, default 8: maximum clocks from `mem_req` to `mem_ack` before abort, range 1..255.

Ports:
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `romc` in 5: ROMC code; sampled only when `cyc_stb` is high.
- `cyc_stb` in 1: one-clock pulse marking the start of a machine cycle.
- `db_stb` in 1: one-clock pulse; `db_in` is valid, and marks the end of the cycle.
- `db_in` in 8: CPU data bus value.
- `db_out` out 8: byte driven toward the CPU.
- `db_oe` out 1: `db_out` is valid and driving the bus.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out 8: memory request.
- `mem_ack` in 1, `mem_rdata` in 8: memory completion, accepted only while `mem_req` is high.
- `proto_err` out 1: one-clock pulse on a protocol error or a memory timeout.

## Operation
- Read-fetch ROMC codes 00, 01, 03, 0C, 0E, 11 use PC0; ROMC 02 uses DC0.
  - At `cyc_stb`, the address is latched. If it is inside a readable window (ROM or RAM), the block asserts `mem_req=1` and `mem_we=0` with that address. Otherwise no request is made and `db_oe` stays 0.
- Register-readback ROMC codes drive `db_out` with `db_oe=1` from the clock after `cyc_stb` until `db_stb`:
  - 06: DC0[15:8]; 07: PC1[15:8]; 09: DC0[7:0]; 0B: PC1[7:0]; 1E: PC0[7:0]; 1F: PC0[15:8].
- All address-register updates happen at `db_stb`, using `db_in` (abbreviated db below); sext = sign extension to ADDR_W.
  - 00, 03: PC0+=1. 01: PC0+=sext(db)+1. 02: DC0+=1.
  - 04: PC1=PC0. 0D: PC1=PC0+1. 08: PC1=PC0, PC0={db,db}. 12: PC1=PC0, PC0[7:0]=db.
  - 0A: DC0+=sext(db).
  - 0C, 17: PC0[7:0]=db. 0F, 14: PC0[15:8]=db. 15: PC1[15:8]=db. 18: PC1[7:0]=db.
  - 0E, 19: DC0[7:0]=db. 11, 16: DC0[15:8]=db.
  - 1D: swap DC0 and DC1.
  - All other codes (including 1C): no-op.
- Arithmetic is modulo 2^ADDR_W and wraps silently (FFFF+1=0000).
- Write, ROMC 05: at `db_stb`, if DC0 is inside the RAM window, the block issues `mem_req=1`, `mem_we=1`, `mem_wdata=db`, address DC0. DC0 increments at `db_stb` regardless of the window. A write outside RAM is dropped with no error.
- State machine:
  - IDLE: on `cyc_stb` with a read hit, go to RD_WAIT. On `db_stb` with a write hit, go to WR_WAIT.
  - RD_WAIT: on `mem_ack`, capture `mem_rdata`, set `db_oe=1`, go to DRIVE.
  - DRIVE: hold `db_out`; on `db_stb`, set `db_oe=0` and go to IDLE.
  - WR_WAIT: on `mem_ack`, go to IDLE.
- Timeout: if `TIMEOUT` clocks pass in RD_WAIT or WR_WAIT without `mem_ack`, drop `mem_req`, pulse `proto_err`, and go to IDLE. A timed-out read leaves `db_oe=0`.
- Protocol errors: `cyc_stb` arriving while in RD_WAIT or WR_WAIT aborts the request, pulses `proto_err`, and starts the new cycle. `db_stb` arriving in RD_WAIT applies register updates, abandons the read, and pulses `proto_err`. `db_stb` with no open cycle is ignored.
- Simultaneous `cyc_stb` and `db_stb`: the `db_stb` actions of the old cycle apply first; the new cycle's address is latched from the updated registers.

## Timing
- Reset values: PC0, PC1, DC0, DC1 = 0; `db_out`=8'h00; `db_oe`, `mem_req`, `mem_we`, `proto_err`=0; `mem_addr`, `mem_wdata`=0; state IDLE.
- `rst` mid-request drops `mem_req` on the next edge; a later `mem_ack` is ignored.
- `mem_req` is asserted on the clock after `cyc_stb` for reads, or after `db_stb` for writes. `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are held stable until the `mem_ack` clock or an abort.
- `db_oe` rises on the clock after `mem_ack`, giving a minimum read latency of `cyc_stb` + 2 clocks when memory acks in the same cycle as the request.
- `db_oe` falls on the clock after `db_stb`. Register updates are visible on the clock after `db_stb`.

## Test plan
- Reset, then ROMC 00 fetch with mem_rdata=8'h2A and ack after 3 clocks -> `mem_addr`=0000, `db_out`=2A with `db_oe` 1 until `db_stb`; PC0=0001.
- PC0=0010, ROMC 01, db_in=8'hFE -> PC0=000F. Then ROMC 0A with DC0=8000, db_in=8'h80 -> DC0=7F80.
- DC0=81FF, ROMC 05, db_in=8'h55 -> RAM write to 81FF, DC0=8200. A second ROMC 05 -> no `mem_req`, DC0=8201.
- PC0=4000 (outside both windows), ROMC 00 -> no `mem_req`, `db_oe`=0, PC0=4001.
- ROMC 02 with `mem_ack` withheld -> `mem_req` drops after 8 clocks, `proto_err` pulses once, `db_oe`=0.
- DC0=1234, DC1=ABCD, ROMC 1D -> DC0=ABCD, DC1=1234. PC0=FFFF, ROMC 00 -> PC0=0000. Readback ROMC 1F -> `db_out`=00.
